// File: rtl/reg_wr_initiator_if.sv
// Host-request and register-write signal bundle for reg_wr_initiator.
// master = the initiator; slave = the host/register side driving requests, ack and busy.
interface reg_wr_initiator_if #(
  parameter int WIDTH     = 32,
  parameter int MAX_RETRY = 2
);
  localparam int RCW = $clog2(MAX_RETRY + 1) + 1;

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
  // req_data must be valid whenever req_valid is high, and is ignored while req_ready is low.
  logic             req_valid;
  logic [WIDTH-1:0] req_data;
  logic             req_ready;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             acknowledge;
  logic             reg_busy;
  logic             done;
  logic             error;
  logic [RCW-1:0]   retry_cnt;

  modport master (
    input  req_valid, req_data, acknowledge, reg_busy,
    output req_ready, wr_valid, wr_data, done, error, retry_cnt
  );

  modport slave (
    output req_valid, req_data, acknowledge, reg_busy,
    input  req_ready, wr_valid, wr_data, done, error, retry_cnt
  );
endinterface

// File: rtl/reg_wr_initiator.sv
// Confirmed-write initiator: issues one write strobe per attempt, waits for the
// register's acknowledge, and retries on timeout before reporting done or error.
module reg_wr_initiator #(
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_wr_initiator_if.master   bus,
  output logic [1:0]           dbg_state
);
  localparam int RCW = $clog2(MAX_RETRY + 1) + 1;
  localparam int TW  = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
  localparam logic [RCW-1:0] RMAX  = RCW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    WRITE = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [RCW-1:0]   retry, retry_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             ready_q;
  logic             done_q, done_nxt;
  logic             error_q, error_nxt;
  logic             accept;

  // ready_q is a register so req_ready stays low while reset is held.
  assign accept = bus.req_valid && ready_q;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry;
    data_nxt  = data_q;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          data_nxt  = bus.req_data;
          retry_nxt = '0;
          state_nxt = ARB;
        end
      end
      ARB: begin
        if (!bus.reg_busy) state_nxt = WRITE;
      end
      WRITE: begin
        timer_nxt = '0;
        state_nxt = CHECK;
      end
      CHECK: begin
        // An ack on the last timer cycle still wins over the timeout.
        if (bus.acknowledge) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TLAST) begin
          if (retry < RMAX) begin
            retry_nxt = retry + RCW'(1);
            state_nxt = ARB;
          end else begin
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      retry   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      retry   <= retry_nxt;
      data_q  <= data_nxt;
      ready_q <= (state_nxt == IDLE);
      done_q  <= done_nxt;
      error_q <= error_nxt;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.wr_valid  = (state == WRITE);
  assign bus.wr_data   = data_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.retry_cnt = retry;
  assign dbg_state     = state;
endmodule

// File: tb/tb_reg_wr_initiator.sv
// Randomized bench for reg_wr_initiator: each request's timeline (strobes, retries,
// done/error cycle) is planned arithmetically from attempt stalls and ack delays.
module tb_reg_wr_initiator;
  localparam int WIDTH     = 32;
  localparam int TIMEOUT   = 4;
  localparam int MAX_RETRY = 2;
  localparam int MAXC      = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  reg_wr_initiator_if #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) bus ();

  reg_wr_initiator #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard: every write strobe must carry the next expected data word
  always @(negedge clk) begin
    if (!reset && bus.wr_valid === 1'b1) begin
      if (exp_q.size() == 0) check("wr_unexpected_pulse", 64'(exp_q.size()), 1);
      else check("wr_strobe_data", bus.wr_data, exp_q.pop_front());
    end
  end

  task automatic drive_noise();
    bus.reg_busy    = 1'($urandom_range(1, 0));
    bus.acknowledge = 1'($urandom_range(1, 0));
  endtask

  // Called on a negedge with the DUT idle. nfail = attempts that see no ack
  // (MAX_RETRY+1 means the request ends in error). abort_c > 0 asserts reset in that cycle.
  task automatic run_txn(input logic [WIDTH-1:0] data, input int nfail,
                         input int bmin, input int bmax, input int dmax, input int abort_c);
    logic ev_wv[MAXC], ev_done[MAXC], ev_err[MAXC], in_busy[MAXC], in_ack[MAXC];
    int   exp_rc[MAXC];
    int   c, L, rc, b, d;
    for (int i = 0; i < MAXC; i++) begin
      ev_wv[i] = 0; ev_done[i] = 0; ev_err[i] = 0; exp_rc[i] = 0;
      in_busy[i] = 1'($urandom_range(1, 0));
      in_ack[i]  = 1'($urandom_range(1, 0));
    end
    c = 1; rc = 0; L = 0;
    for (int a = 0; a <= MAX_RETRY && L == 0; a++) begin
      b = int'($urandom_range(bmax, bmin));
      for (int k = 0; k < b; k++) begin in_busy[c] = 1; exp_rc[c] = rc; c++; end
      in_busy[c] = 0; exp_rc[c] = rc; c++;
      ev_wv[c] = 1; exp_rc[c] = rc; c++;
      if (a < nfail) begin
        for (int k = 0; k < TIMEOUT; k++) begin in_ack[c] = 0; exp_rc[c] = rc; c++; end
        if (a == MAX_RETRY) begin ev_err[c] = 1; exp_rc[c] = rc; L = c; end
        else rc++;
      end else begin
        d = int'($urandom_range(dmax, 0));
        for (int k = 0; k < d; k++) begin in_ack[c] = 0; exp_rc[c] = rc; c++; end
        in_ack[c] = 1; exp_rc[c] = rc; c++;
        ev_done[c] = 1; exp_rc[c] = rc; L = c;
      end
    end

    check("req_ready_at_accept", bus.req_ready, 1);
    bus.req_valid   = 1'b1;
    bus.req_data    = data;
    bus.reg_busy    = in_busy[0];
    bus.acknowledge = in_ack[0];
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      check($sformatf("wr_valid@c%0d", k),  bus.wr_valid,  ev_wv[k]);
      check($sformatf("done@c%0d", k),      bus.done,      ev_done[k]);
      check($sformatf("error@c%0d", k),     bus.error,     ev_err[k]);
      check($sformatf("req_ready@c%0d", k), bus.req_ready, k == L);
      check($sformatf("retry_cnt@c%0d", k), bus.retry_cnt, exp_rc[k]);
      check($sformatf("wr_data@c%0d", k),   bus.wr_data,   data);
      if (k < L && ev_wv[k+1]) exp_q.push_back(data);
      bus.req_valid   = (k < L) ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.req_data    = $urandom;
      bus.reg_busy    = in_busy[k];
      bus.acknowledge = in_ack[k];
      if (k == abort_c) begin
        bus.req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("wr_valid_async_drop", bus.wr_valid,  0);
        check("req_ready_in_reset",  bus.req_ready, 0);
        check("done_in_reset",       bus.done,      0);
        check("error_in_reset",      bus.error,     0);
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_done",      bus.done,      0);
      check("idle_error",     bus.error,     0);
      check("idle_wr_valid",  bus.wr_valid,  0);
      check("idle_req_ready", bus.req_ready, 1);
      bus.req_valid = 1'b0;
      bus.req_data  = $urandom;
      drive_noise();
    end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_data    = '0;
    bus.reg_busy    = 1'b0;
    bus.acknowledge = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_wr_valid",  bus.wr_valid,  0);
    check("rst_wr_data",   bus.wr_data,   0);
    check("rst_done",      bus.done,      0);
    check("rst_error",     bus.error,     0);
    check("rst_retry_cnt", bus.retry_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.req_ready, 1);

    // nominal: strobe at c2, done at c4
    run_txn(32'hA5A5_0001, 0, 0, 0, 0, -1);
    idle(2);
    // busy stall of 5 cycles: strobe at c7, done at c9
    run_txn(32'h1234_5678, 0, 5, 5, 0, -1);
    idle(1);
    // first attempt times out: second strobe at c8
    run_txn(32'hDEAD_BEEF, 1, 0, 0, 0, -1);
    idle(1);
    // ack never arrives: three strobes, error at c19
    run_txn(32'h0BAD_0BAD, MAX_RETRY + 1, 0, 0, 0, -1);
    idle(1);
    // back-to-back requests accepted in the done cycle
    run_txn(32'h0000_0000, 0, 0, 2, TIMEOUT - 1, -1);
    run_txn(32'hFFFF_FFFF, 0, 0, 2, TIMEOUT - 1, -1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, int'($urandom_range(MAX_RETRY + 1, 0)), 0, 3, TIMEOUT - 1, -1);
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(2, 1)));
    end

    // reset asserted while the strobe is high
    run_txn(32'h5555_AAAA, 0, 0, 0, 0, 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_held_in_reset", bus.req_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1);
    check("post_rst_wr_data",   bus.wr_data,   0);
    check("post_rst_retry_cnt", bus.retry_cnt, 0);
    check("post_rst_wr_valid",  bus.wr_valid,  0);
    check("post_rst_done",      bus.done,      0);
    check("post_rst_error",     bus.error,     0);
    run_txn(32'h0F0F_F0F0, 1, 0, 1, TIMEOUT - 1, -1);
    idle(1);

    check("exp_q_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
